// File: rtl/elbeth_fetch_unit.sv
// rtl/elbeth_fetch_unit.sv - instruction fetch stage with output slot, one-entry skid and redirect drain
// Optional feature: define ELBETH_FETCH_PERF_EN to add the perf_fetch_count output.
module elbeth_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ctrl_stall,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic        if_valid
`ifdef ELBETH_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] pc;
   logic [31:0] drain_addr;
   logic [31:0] sk_instr;
   logic [31:0] sk_pc;
   logic        sk_valid;
   logic        fetch_req;
   logic        accept;
   logic [31:0] redirect_pc;
   logic        unused_tgt_lsb;

   assign redirect_pc    = {ex_branch_target[31:2], 2'b00};
   assign unused_tgt_lsb = &{1'b0, ex_branch_target[1:0]};

   // A full skid slot throttles the memory side; fetch resumes when it empties.
   assign fetch_req = (state == ST_FETCH) && !sk_valid;
   assign accept    = fetch_req && imem_ready && !ex_branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      imem_req  = 1'b0;
      imem_addr = pc;
      case (state)
         ST_IDLE: begin
            state_nx = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = fetch_req;
            if (ex_branch_taken && fetch_req && !imem_ready) begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The abandoned request keeps its original address until memory acknowledges it.
            imem_req  = 1'b1;
            imem_addr = drain_addr;
            if (imem_ready) begin
               state_nx = ST_FETCH;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         drain_addr <= 32'h0;
      end else begin
         if (ex_branch_taken) begin
            pc <= redirect_pc;
         end else if (accept) begin
            pc <= pc + 32'd4;
         end
         if (state == ST_FETCH && state_nx == ST_DRAIN) begin
            drain_addr <= pc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid       <= 1'b0;
         if_instruction <= 32'h0;
         if_pc          <= 32'h0;
         sk_valid       <= 1'b0;
         sk_instr       <= 32'h0;
         sk_pc          <= 32'h0;
      end else if (ex_branch_taken) begin
         if_valid       <= 1'b0;
         if_instruction <= 32'h0;
         if_pc          <= 32'h0;
         sk_valid       <= 1'b0;
         sk_instr       <= 32'h0;
         sk_pc          <= 32'h0;
      end else if (!ctrl_stall) begin
         if (sk_valid) begin
            if_valid       <= 1'b1;
            if_instruction <= sk_instr;
            if_pc          <= sk_pc;
            sk_valid       <= 1'b0;
            sk_instr       <= 32'h0;
            sk_pc          <= 32'h0;
         end else if (accept) begin
            if_valid       <= 1'b1;
            if_instruction <= imem_rdata;
            if_pc          <= pc;
         end else begin
            if_valid       <= 1'b0;
            if_instruction <= 32'h0;
            if_pc          <= 32'h0;
         end
      end else if (accept) begin
         // Stalled: an empty output slot still fills; a full one spills into the skid.
         if (!if_valid) begin
            if_valid       <= 1'b1;
            if_instruction <= imem_rdata;
            if_pc          <= pc;
         end else begin
            sk_valid <= 1'b1;
            sk_instr <= imem_rdata;
            sk_pc    <= pc;
         end
      end
   end

`ifdef ELBETH_FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_count <= 32'h0;
      end else if (if_valid && !ctrl_stall) begin
         perf_fetch_count <= perf_fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/elbeth_fetch_unit.md
ELBETH_FETCH_UNIT -- requirements
Module: elbeth_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ctrl_stall  input  1  decode stage not accepting this cycle (same signal as IF/ID stall).
REQ-005 SHALL have port: ex_branch_taken  input  1  one-cycle redirect request.
REQ-006 SHALL have port: ex_branch_target  input  32  redirect address; bits [1:0] ignored (forced 00).
REQ-007 SHALL have port: imem_req  output  1  instruction memory request.
REQ-008 SHALL have port: imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
REQ-009 SHALL have port: imem_ready  input  1  same-cycle acknowledge; imem_rdata valid when high.
REQ-010 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port: if_instruction  output  32  instruction presented to IF/ID; 32'h0 when if_valid=0.
REQ-012 SHALL have port: if_pc  output  32  address of if_instruction; 32'h0 when if_valid=0.
REQ-013 SHALL have port: if_valid  output  1  if_instruction/if_pc hold a real instruction.

Function
REQ-014 SHALL hold state: pc register, FSM {IDLE, FETCH, DRAIN}, registered output slot (if_*), one-entry skid slot (sk_instr, sk_pc, sk_valid).
REQ-015 SHALL leave IDLE for FETCH on the first rising edge after rst_n deasserts; imem_req=0 in IDLE.
REQ-016 SHALL drive imem_req=1 in FETCH when sk_valid=0, in DRAIN always, else 0; imem_addr=pc; once raised, imem_req and imem_addr SHALL hold until imem_ready=1.
REQ-017 SHALL, on each accepted response (FETCH, imem_ready=1, no redirect), set pc<=pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 SHALL route accepted response: ctrl_stall=0 or if_valid=0 -> output slot; ctrl_stall=1 and if_valid=1 -> skid slot.
REQ-019 SHALL, on an edge with ctrl_stall=0: load output slot from skid if sk_valid=1 (then sk_valid<=0), else from accepted response, else if_valid<=0.
REQ-020 SHALL hold output slot unchanged while ctrl_stall=1 and if_valid=1.
REQ-021 SHALL achieve latency 1: response accepted in cycle N appears on if_* in cycle N+1; throughput 1 instr/cycle with zero-wait memory and no stall.
REQ-022 SHALL, on ex_branch_taken=1 (priority over ctrl_stall and imem_ready): pc<={target[31:2],2'b00}, if_valid<=0, sk_valid<=0, any same-cycle response discarded.
REQ-023 SHALL, on redirect while imem_req=1 and imem_ready=0, enter DRAIN; DRAIN keeps old imem_addr until imem_ready=1, discards that data, then returns to FETCH at the redirected pc.
REQ-024 SHALL, on redirect during DRAIN, update pc to the newest target and remain in DRAIN.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instruction=0, if_pc=0, sk_valid=0, sk_instr=0, sk_pc=0.
REQ-026 SHALL abandon any outstanding request on reset; no response is captured after reset asserts.

Configuration
REQ-027 SHALL, with ELBETH_FETCH_PERF_EN defined, add output perf_fetch_count[31:0]: increments on each edge with if_valid=1 and ctrl_stall=0, reset to 0, wraps at 2^32.
REQ-028 SHALL, without ELBETH_FETCH_PERF_EN, omit the port and counter; all other behaviour identical.

Verification
REQ-029 SHALL cover: reset release, imem_ready tied 1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; if_pc 0x0,0x4,0x8 one cycle later, if_valid=1.
REQ-030 SHALL cover: ctrl_stall=1 for 3 cycles with if_pc=0x8 -> if_pc holds 0x8, response 0xC to skid, imem_req=0; release -> if_pc 0xC then 0x10, no loss or duplicate.
REQ-031 SHALL cover: ex_branch_taken=1, target 0x0000_0103, ready=1 -> if_valid=0 next cycle, next imem_addr=0x100.
REQ-032 SHALL cover: redirect to 0x200 while imem_ready=0 at 0x40 -> DRAIN holds 0x40 until ready, data dropped, next imem_addr=0x200.
REQ-033 SHALL cover: RESET_PC=0xFFFF_FFFC -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-034 SHALL cover: rst_n low mid-wait -> imem_req=0 and if_valid=0 immediately, without clock edge.
